series_job_scheduler: RTL
=========================

// Module: series_job_scheduler
// PURPOSE
//   Shares one series-evaluation engine (controller + x/y/r/t datapath, start/ready
//   handshake) between N_REQ requesters. Round-robin arbitration; per job: latch
//   operand, pulse engine start, track engine ready low->high, capture result,
//   return a one-cycle done to the winner. Sits between client blocks and engine top.
// PARAMETERS
//   N_REQ    4    number of requesters (>=2)
//   DW       16   operand/result width
//   TIMEOUT  255  max cycles in WAIT_BUSY+WAIT_DONE before the job is aborted (<2^12)
// PORTS
//   clk         in   1         system clock, rising edge; single clock domain
//   rst         in   1         synchronous, active-high reset
//   req         in   N_REQ     level request per requester; held until its done
//   req_x       in   N_REQ*DW  operand of requester i at bits [i*DW +: DW]
//   grant       out  N_REQ     one-hot owner of current job; 0 when idle
//   done        out  N_REQ     one-cycle pulse to owner when job ends
//   err         out  1         one-cycle pulse with done when job timed out
//   result      out  DW        job result; valid in the done cycle, held until next done
//   busy        out  1         1 in any state other than IDLE
//   eng_start   out  1         start pulse to engine, exactly one cycle per job
//   eng_x       out  DW        operand to engine, stable from ARB until next ARB
//   eng_ready   in   1         engine idle/finished flag
//   eng_result  in   DW        engine result, valid while eng_ready=1 after a job
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE, rr_ptr=0, grant=0, done=0, err=0,
//     result=0, busy=0, eng_start=0, eng_x=0, timer=0. Reset mid-job abandons the
//     job with no done; the engine is not reset by this block.
//   FSM (all outputs registered):
//   IDLE: leave only when |req && eng_ready; go ARB.
//   ARB (1 cycle): winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ...
//     mod N_REQ; grant<=onehot(winner), eng_x<=req_x[winner]; go LAUNCH. If req fell
//     to 0 meanwhile, go IDLE, grant stays 0.
//   LAUNCH (1 cycle): eng_start=1; timer<=0; go WAIT_BUSY.
//   WAIT_BUSY: wait eng_ready=0 (engine accepted); go WAIT_DONE.
//   WAIT_DONE: wait eng_ready=1; result<=eng_result; go DELIVER.
//   Timer increments each cycle in WAIT_BUSY/WAIT_DONE; on timer==TIMEOUT-1 without
//     exit, result<=0, err flag set, go DELIVER.
//   DELIVER (1 cycle): done=grant, err=flag; then grant<=0, flag<=0,
//     rr_ptr<=(winner+1) mod N_REQ; go IDLE.
//   Latency, uncontended, instant engine: req rises at edge k -> ARB k+1, eng_start
//     k+2, done = k+2 + engine cycles + 3.
//   Owner dropping req after grant: job still runs, done still pulses to it.
//   req_x changes after ARB are ignored. Owner re-requesting in its DELIVER cycle
//     gets lowest priority next ARB. Non-owner requests wait; never lost.
//   Engine ready=0 in IDLE with pending req: stay IDLE, no grant.
//   Exactly one eng_start per job; no eng_start outside LAUNCH.
// TESTING
//   1 Reset: rst=1 2 cycles -> all outputs 0, busy=0; rst mid-WAIT_DONE -> IDLE,
//     no done, grant=0 next cycle.
//   2 Single job: req=4'b0010, x=16'h0003, model returns 16'h0014 after 10 cycles ->
//     grant=0010, one eng_start, eng_x=0003, done=0010 once, result=0014, err=0.
//   3 Round-robin: req=4'b1111 held, each served then dropped -> done order
//     0001,0010,0100,1000; then req=1111 again -> 0001 first (rr_ptr wrapped to 0).
//   4 Fairness: req[0] re-asserted in its own DELIVER while req[2]=1 -> next
//     grant=0100, then 0001.
//   5 Timeout: TIMEOUT=20, engine never raises ready -> done=owner, err=1, result=0
//     exactly 20 cycles after LAUNCH; FSM returns IDLE.
//   6 Engine busy at request: eng_ready=0, req=0001 -> no grant/eng_start until
//     ready=1, then normal job; req dropped after grant -> done still pulses.

Source files
------------

// File: rtl/series_job_scheduler.sv
// Round-robin front end sharing one series-evaluation engine between
// N_REQ requesters.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req, req_x            level requests and packed operands (DW bits each)
//   grant, done, err      job owner, one-cycle done pulse, timeout flag
//   result                result of the last job, held until the next done
//   busy                  high whenever the scheduler is not idle
//   eng_start, eng_x      start pulse and operand to the engine
//   eng_ready, eng_result engine handshake and result
module series_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic [DW-1:0]       result,
    output logic                busy,
    output logic                eng_start,
    output logic [DW-1:0]       eng_x,
    input  logic                eng_ready,
    input  logic [DW-1:0]       eng_result
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = 12;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PLAST = PW'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WBUSY,
        S_WDONE,
        S_DELIV
    } state_t;

    state_t state, state_n;

    logic [PW-1:0]    rr_ptr, rr_ptr_n;
    logic [PW-1:0]    owner, owner_n;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic [TW-1:0]    timer, timer_n;
    logic             tmo_exit;
    logic [N_REQ-1:0] grant_n, done_n;
    logic             err_n, busy_n, eng_start_n;
    logic [DW-1:0]    result_n, eng_x_n;

    // Scan from the far end back toward rr_ptr so the last hit is the
    // first requester in round-robin order.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (req[PW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            timer     <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_x     <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            owner     <= owner_n;
            timer     <= timer_n;
            grant     <= grant_n;
            done      <= done_n;
            err       <= err_n;
            result    <= result_n;
            busy      <= busy_n;
            eng_start <= eng_start_n;
            eng_x     <= eng_x_n;
        end
    end

    // A ready edge in the same cycle as the last timer tick still counts
    // as a normal completion.
    always_comb begin
        state_n  = state;
        tmo_exit = 1'b0;
        unique case (state)
            S_IDLE:
                if (|req && eng_ready)
                    state_n = S_ARB;
            S_ARB:
                state_n = win_found ? S_LAUNCH : S_IDLE;
            S_LAUNCH:
                state_n = S_WBUSY;
            S_WBUSY:
                if (!eng_ready) begin
                    state_n = S_WDONE;
                end else if (timer == TLAST) begin
                    state_n  = S_DELIV;
                    tmo_exit = 1'b1;
                end
            S_WDONE:
                if (eng_ready) begin
                    state_n = S_DELIV;
                end else if (timer == TLAST) begin
                    state_n  = S_DELIV;
                    tmo_exit = 1'b1;
                end
            S_DELIV:
                state_n = S_IDLE;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_comb begin
        grant_n  = grant;
        owner_n  = owner;
        eng_x_n  = eng_x;
        timer_n  = timer;
        rr_ptr_n = rr_ptr;
        result_n = result;
        unique case (state)
            S_ARB:
                if (win_found) begin
                    grant_n          = '0;
                    grant_n[win_idx] = 1'b1;
                    owner_n          = win_idx;
                    eng_x_n = req_x[int'(win_idx)*DW +: DW];
                end
            S_LAUNCH:
                timer_n = '0;
            S_WBUSY:
                timer_n = timer + TW'(1);
            S_WDONE: begin
                timer_n = timer + TW'(1);
                if (eng_ready)
                    result_n = eng_result;
            end
            S_DELIV: begin
                grant_n  = '0;
                rr_ptr_n = (owner == PLAST) ? '0 : owner + PW'(1);
            end
            default: ;
        endcase
        if (tmo_exit)
            result_n = '0;
        done_n      = (state_n == S_DELIV) ? grant_n : '0;
        err_n       = tmo_exit;
        busy_n      = (state_n != S_IDLE);
        eng_start_n = (state_n == S_LAUNCH);
    end

endmodule
